// File: rtl/calc2_pkg.sv
// Shared calc2 definitions: command/response codes, bus widths, send-FSM states
// and a lowest-set-bit helper used for tag allocation and expiry arbitration.
package calc2_pkg;

    localparam int TAG_W    = 2;
    localparam int DATA_W   = 32;
    localparam int CMD_W    = 4;
    localparam int RESP_W   = 2;
    localparam int NUM_TAGS = 4;
    localparam int CNT_W    = 10;

    localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
    localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
    localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

    localparam logic [RESP_W-1:0] RESP_NONE = 2'd0;
    localparam logic [RESP_W-1:0] RESP_OK   = 2'd1;
    localparam logic [RESP_W-1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {IDLE, SEND1, SEND2} send_state_t;

    // Scanning downwards leaves the lowest set index as the final answer.
    function automatic logic [TAG_W-1:0] lowest_set(input logic [NUM_TAGS-1:0] mask);
        lowest_set = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set = TAG_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/calc2_tag_tracker.sv
// Tag bookkeeping for one calc2 port: free mask, lowest-free allocation,
// per-tag timeout counters, response matching and timeout retirement.
module calc2_tag_tracker
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_alloc,
    input  logic             i_resp_valid,
    input  logic [TAG_W-1:0] i_resp_tag,
    output logic             o_any_free,
    output logic [TAG_W-1:0] o_alloc_tag,
    output logic             o_resp_hit,
    output logic             o_retire_valid,
    output logic [TAG_W-1:0] o_retire_tag,
    output logic             o_outstanding_next
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [NUM_TAGS-1:0] r_free;
    logic [CNT_W-1:0]    r_cnt [NUM_TAGS];
    logic [NUM_TAGS-1:0] w_expired;
    logic [NUM_TAGS-1:0] w_free_next;

    always_comb begin
        w_expired = '0;
        for (int i = 0; i < NUM_TAGS; i++) begin
            w_expired[i] = !r_free[i] && (r_cnt[i] == LIMIT);
        end
    end

    assign o_any_free     = |r_free;
    assign o_alloc_tag    = lowest_set(r_free);
    assign o_resp_hit     = i_resp_valid && !r_free[i_resp_tag];
    assign o_retire_valid = !o_resp_hit && (|w_expired);
    assign o_retire_tag   = lowest_set(w_expired);

    // Allocation only ever picks a tag already free in r_free, so it can never
    // collide with a tag being freed on the same edge.
    always_comb begin
        w_free_next = r_free;
        if (o_resp_hit) begin
            w_free_next[i_resp_tag] = 1'b1;
        end
        if (o_retire_valid) begin
            w_free_next[o_retire_tag] = 1'b1;
        end
        if (i_alloc) begin
            w_free_next[o_alloc_tag] = 1'b0;
        end
    end

    assign o_outstanding_next = ~&w_free_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_free <= '1;
            for (int i = 0; i < NUM_TAGS; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_free <= w_free_next;
            for (int i = 0; i < NUM_TAGS; i++) begin
                if (i_alloc && (o_alloc_tag == TAG_W'(i))) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] != LIMIT) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc2_port_driver.sv
// Request-side initiator for one calc2 port: serialises host operations into
// the two-beat command/operand sequence and reports matched or timed-out results.
module calc2_port_driver
    import calc2_pkg::*;
#(
    parameter int TIMEOUT = 64
)
(
    input  logic        c_clk,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [0:3]  op_cmd,
    input  logic [0:31] op_a,
    input  logic [0:31] op_b,
    output logic [0:1]  op_tag,
    output logic [0:3]  req_cmd_out,
    output logic [0:31] req_data_out,
    output logic [0:1]  req_tag_out,
    input  logic [0:1]  resp_in,
    input  logic [0:31] resp_data_in,
    input  logic [0:1]  resp_tag_in,
    output logic        res_valid,
    output logic [0:1]  res_resp,
    output logic [0:31] res_data,
    output logic [0:1]  res_tag,
    output logic        res_timeout,
    output logic        spurious_err,
    output logic        busy
);

    send_state_t       r_state;
    logic [DATA_W-1:0] r_b;
    logic [CMD_W-1:0]  r_req_cmd;
    logic [DATA_W-1:0] r_req_data;
    logic [TAG_W-1:0]  r_req_tag;
    logic              r_res_valid;
    logic [RESP_W-1:0] r_res_resp;
    logic [DATA_W-1:0] r_res_data;
    logic [TAG_W-1:0]  r_res_tag;
    logic              r_res_timeout;
    logic              r_spurious;
    logic              r_busy;

    logic              w_any_free;
    logic [TAG_W-1:0]  w_alloc_tag;
    logic              w_resp_hit;
    logic              w_retire_valid;
    logic [TAG_W-1:0]  w_retire_tag;
    logic              w_outstanding_next;
    logic              w_accept;
    logic              w_resp_valid;

    assign op_ready     = ((r_state == IDLE) || (r_state == SEND2)) && w_any_free;
    assign op_tag       = w_alloc_tag;
    assign w_accept     = op_valid && op_ready;
    assign w_resp_valid = (resp_in != RESP_NONE);

    calc2_tag_tracker #(
        .TIMEOUT(TIMEOUT)
    ) u_tracker (
        .clk               (c_clk),
        .reset             (reset),
        .i_alloc           (w_accept),
        .i_resp_valid      (w_resp_valid),
        .i_resp_tag        (resp_tag_in),
        .o_any_free        (w_any_free),
        .o_alloc_tag       (w_alloc_tag),
        .o_resp_hit        (w_resp_hit),
        .o_retire_valid    (w_retire_valid),
        .o_retire_tag      (w_retire_tag),
        .o_outstanding_next(w_outstanding_next)
    );

    // Request beats are registered, so the beat loaded at the accept edge is
    // on the bus for the whole SEND1 cycle; SEND2 may accept the next op.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_b        <= '0;
            r_req_cmd  <= CMD_NOP;
            r_req_data <= '0;
            r_req_tag  <= '0;
        end else begin
            case (r_state)
                IDLE, SEND2: begin
                    if (w_accept) begin
                        r_state    <= SEND1;
                        r_req_cmd  <= op_cmd;
                        r_req_data <= op_a;
                        r_req_tag  <= w_alloc_tag;
                        r_b        <= op_b;
                    end else begin
                        r_state    <= IDLE;
                        r_req_cmd  <= CMD_NOP;
                        r_req_data <= '0;
                        r_req_tag  <= '0;
                    end
                end
                SEND1: begin
                    r_state    <= SEND2;
                    r_req_cmd  <= CMD_NOP;
                    r_req_data <= r_b;
                    r_req_tag  <= '0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_req_cmd  <= CMD_NOP;
                    r_req_data <= '0;
                    r_req_tag  <= '0;
                end
            endcase
        end
    end

    // A matched response always beats a pending timeout retirement.
    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            r_res_valid   <= 1'b0;
            r_res_resp    <= RESP_NONE;
            r_res_data    <= '0;
            r_res_tag     <= '0;
            r_res_timeout <= 1'b0;
            r_spurious    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_res_valid <= w_resp_hit || w_retire_valid;
            r_spurious  <= w_resp_valid && !w_resp_hit;
            r_busy      <= w_outstanding_next || w_accept || (r_state == SEND1);
            if (w_resp_hit) begin
                r_res_resp    <= resp_in;
                r_res_data    <= resp_data_in;
                r_res_tag     <= resp_tag_in;
                r_res_timeout <= 1'b0;
            end else if (w_retire_valid) begin
                r_res_resp    <= RESP_NONE;
                r_res_data    <= '0;
                r_res_tag     <= w_retire_tag;
                r_res_timeout <= 1'b1;
            end else begin
                r_res_resp    <= RESP_NONE;
                r_res_data    <= '0;
                r_res_tag     <= '0;
                r_res_timeout <= 1'b0;
            end
        end
    end

    assign req_cmd_out  = r_req_cmd;
    assign req_data_out = r_req_data;
    assign req_tag_out  = r_req_tag;
    assign res_valid    = r_res_valid;
    assign res_resp     = r_res_resp;
    assign res_data     = r_res_data;
    assign res_tag      = r_res_tag;
    assign res_timeout  = r_res_timeout;
    assign spurious_err = r_spurious;
    assign busy         = r_busy;

endmodule

// File: tb/tb_calc2_port_driver.sv
// Self-checking bench for calc2_port_driver: directed scenarios plus a random
// run compared against a tag/age/beat-queue reference model.
module tb_calc2_port_driver;

    localparam int TMO = 16;

    logic        c_clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [0:3]  op_cmd = '0;
    logic [0:31] op_a = '0;
    logic [0:31] op_b = '0;
    logic [0:1]  op_tag;
    logic [0:3]  req_cmd_out;
    logic [0:31] req_data_out;
    logic [0:1]  req_tag_out;
    logic [0:1]  resp_in = '0;
    logic [0:31] resp_data_in = '0;
    logic [0:1]  resp_tag_in = '0;
    logic        res_valid;
    logic [0:1]  res_resp;
    logic [0:31] res_data;
    logic [0:1]  res_tag;
    logic        res_timeout;
    logic        spurious_err;
    logic        busy;

    int errors = 0;
    int checks = 0;

    calc2_port_driver #(.TIMEOUT(TMO)) dut (
        .c_clk(c_clk), .reset(reset),
        .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd),
        .op_a(op_a), .op_b(op_b), .op_tag(op_tag),
        .req_cmd_out(req_cmd_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
        .resp_in(resp_in), .resp_data_in(resp_data_in), .resp_tag_in(resp_tag_in),
        .res_valid(res_valid), .res_resp(res_resp), .res_data(res_data),
        .res_tag(res_tag), .res_timeout(res_timeout),
        .spurious_err(spurious_err), .busy(busy)
    );

    always #5 c_clk = ~c_clk;

    // Reference model: which tags are out, how many edges old each is, and the
    // queue of request beats still owed to the bus.
    typedef struct {
        logic [0:3]  cmd;
        logic [0:31] data;
        logic [0:1]  tag;
    } beat_t;

    bit [3:0]    m_out;
    int          m_age [4];
    beat_t       m_q [$];
    logic [0:3]  e_req_cmd;
    logic [0:31] e_req_data;
    logic [0:1]  e_req_tag;
    logic        e_res_valid;
    logic [0:1]  e_res_resp;
    logic [0:31] e_res_data;
    logic [0:1]  e_res_tag;
    logic        e_res_to;
    logic        e_spur;
    logic        e_busy;

    function automatic bit m_ready();
        return (m_q.size() == 0) && (m_out != 4'hF);
    endfunction

    function automatic int m_free_tag();
        for (int i = 0; i < 4; i++) begin
            if (!m_out[i]) return i;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        m_out = '0;
        for (int i = 0; i < 4; i++) m_age[i] = 0;
        m_q.delete();
        e_req_cmd = '0; e_req_data = '0; e_req_tag = '0;
        e_res_valid = 0; e_res_resp = '0; e_res_data = '0; e_res_tag = '0;
        e_res_to = 0; e_spur = 0; e_busy = 0;
    endfunction

    function automatic void model_edge();
        bit    acc;
        bit    hit;
        bit    sending;
        int    at;
        int    rt;
        beat_t b;
        acc = op_valid && m_ready();
        at  = m_free_tag();
        hit = (resp_in != 0) && m_out[resp_tag_in];
        rt  = -1;
        for (int i = 0; i < 4; i++) begin
            if (rt < 0 && m_out[i] && m_age[i] >= TMO) rt = i;
        end
        e_spur = (resp_in != 0) && !hit;
        e_res_valid = 0; e_res_resp = '0; e_res_data = '0; e_res_tag = '0; e_res_to = 0;
        if (hit) begin
            e_res_valid = 1; e_res_resp = resp_in; e_res_data = resp_data_in;
            e_res_tag = resp_tag_in;
        end else if (rt >= 0) begin
            e_res_valid = 1; e_res_tag = 2'(rt); e_res_to = 1;
        end
        for (int i = 0; i < 4; i++) m_age[i]++;
        if (hit) m_out[resp_tag_in] = 1'b0;
        else if (rt >= 0) m_out[rt] = 1'b0;
        if (acc) begin
            m_out[at] = 1'b1;
            m_age[at] = 0;
            m_q.push_back('{op_cmd, op_a, 2'(at)});
            m_q.push_back('{4'd0, op_b, 2'd0});
        end
        sending = 0;
        e_req_cmd = '0; e_req_data = '0; e_req_tag = '0;
        if (m_q.size() > 0) begin
            b = m_q.pop_front();
            e_req_cmd = b.cmd; e_req_data = b.data; e_req_tag = b.tag;
            sending = 1;
        end
        e_busy = (m_out != 0) || sending;
    endfunction

    task automatic tick();
        @(posedge c_clk);
        if (!reset) model_edge();
        @(negedge c_clk);
    endtask

    task automatic do_reset();
        @(negedge c_clk);
        reset = 1'b1; op_valid = 1'b0; resp_in = '0;
        model_reset();
        repeat (2) @(negedge c_clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge c_clk);
        checks++; if ({req_cmd_out, req_data_out, req_tag_out} !== 38'd0) begin errors++; $display("[TB] FAIL reset_req: got %0h expected 0", {req_cmd_out, req_data_out, req_tag_out}); end
        checks++; if ({res_valid, res_resp, res_data, res_tag, res_timeout} !== 38'd0) begin errors++; $display("[TB] FAIL reset_res: got %0h expected 0", {res_valid, res_resp, res_data, res_tag, res_timeout}); end
        checks++; if ({spurious_err, busy} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {spurious_err, busy}); end
        reset = 1'b0;
        tick();
        checks++; if (op_ready !== 1'b1 || op_tag !== 2'd0) begin errors++; $display("[TB] FAIL reset_ready: got ready=%b tag=%0d expected ready=1 tag=0", op_ready, op_tag); end
    endtask

    task automatic test_add();
        do_reset();
        op_valid = 1; op_cmd = 4'd1; op_a = 32'd10; op_b = 32'd25;
        checks++; if (op_ready !== 1'b1 || op_tag !== 2'd0) begin errors++; $display("[TB] FAIL add_accept: got ready=%b tag=%0d expected ready=1 tag=0", op_ready, op_tag); end
        tick();
        op_valid = 0;
        checks++; if (req_cmd_out !== 4'd1 || req_data_out !== 32'd10 || req_tag_out !== 2'd0) begin errors++; $display("[TB] FAIL add_send1: got %0d/%0d/%0d expected 1/10/0", req_cmd_out, req_data_out, req_tag_out); end
        tick();
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd25 || req_tag_out !== 2'd0) begin errors++; $display("[TB] FAIL add_send2: got %0d/%0d/%0d expected 0/25/0", req_cmd_out, req_data_out, req_tag_out); end
        tick();
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL add_idle: got cmd=%0d data=%0d busy=%b expected 0/0/1", req_cmd_out, req_data_out, busy); end
        resp_in = 2'd1; resp_data_in = 32'd35; resp_tag_in = 2'd0;
        tick();
        resp_in = 2'd0;
        checks++; if (res_valid !== 1'b1 || res_resp !== 2'd1 || res_data !== 32'd35 || res_tag !== 2'd0 || res_timeout !== 1'b0) begin errors++; $display("[TB] FAIL add_result: got v=%b r=%0d d=%0d t=%0d to=%b expected 1/1/35/0/0", res_valid, res_resp, res_data, res_tag, res_timeout); end
        tick();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL add_after: got v=%b busy=%b expected 0/0", res_valid, busy); end
    endtask

    task automatic test_sub();
        do_reset();
        op_valid = 1; op_cmd = 4'd2; op_a = 32'd5; op_b = 32'd9;
        tick();
        op_valid = 0;
        tick(); tick();
        resp_in = 2'd2; resp_data_in = 32'd0; resp_tag_in = 2'd0;
        tick();
        resp_in = 2'd0;
        checks++; if (res_valid !== 1'b1 || res_resp !== 2'd2 || res_timeout !== 1'b0) begin errors++; $display("[TB] FAIL sub_err: got v=%b r=%0d to=%b expected 1/2/0", res_valid, res_resp, res_timeout); end
    endtask

    task automatic test_exhaust();
        bit exp_ready;
        do_reset();
        op_valid = 1; op_cmd = 4'd1; op_b = 32'd3;
        for (int i = 0; i < 10; i++) begin
            exp_ready = (i % 2 == 0) && (i < 8);
            checks++; if (op_ready !== exp_ready) begin errors++; $display("[TB] FAIL exhaust_ready_%0d: got %b expected %b", i, op_ready, exp_ready); end
            if (exp_ready) begin
                checks++; if (op_tag !== 2'(i / 2)) begin errors++; $display("[TB] FAIL exhaust_tag_%0d: got %0d expected %0d", i, op_tag, i / 2); end
            end
            op_a = 32'(i);
            if (i == 9) begin
                resp_in = 2'd1; resp_data_in = 32'd7; resp_tag_in = 2'd2;
            end
            tick();
        end
        resp_in = 2'd0;
        checks++; if (op_ready !== 1'b1 || op_tag !== 2'd2) begin errors++; $display("[TB] FAIL exhaust_reuse: got ready=%b tag=%0d expected 1/2", op_ready, op_tag); end
        checks++; if (res_valid !== 1'b1 || res_tag !== 2'd2) begin errors++; $display("[TB] FAIL exhaust_res: got v=%b t=%0d expected 1/2", res_valid, res_tag); end
        tick();
        op_valid = 0;
        checks++; if (req_tag_out !== 2'd2) begin errors++; $display("[TB] FAIL exhaust_send: got %0d expected 2", req_tag_out); end
    endtask

    task automatic test_timeout();
        do_reset();
        op_valid = 1; op_cmd = 4'd1; op_a = 32'd1; op_b = 32'd2;
        tick();
        op_valid = 0;
        for (int n = 1; n <= TMO; n++) begin
            tick();
            checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL timeout_early_%0d: got %b expected 0", n, res_valid); end
        end
        checks++; if (op_tag !== 2'd1) begin errors++; $display("[TB] FAIL timeout_held: got %0d expected 1", op_tag); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_timeout !== 1'b1 || res_tag !== 2'd0 || res_resp !== 2'd0 || res_data !== 32'd0) begin errors++; $display("[TB] FAIL timeout_res: got v=%b to=%b t=%0d r=%0d d=%0d expected 1/1/0/0/0", res_valid, res_timeout, res_tag, res_resp, res_data); end
        checks++; if (op_ready !== 1'b1 || op_tag !== 2'd0) begin errors++; $display("[TB] FAIL timeout_reuse: got ready=%b tag=%0d expected 1/0", op_ready, op_tag); end
    endtask

    task automatic test_collision();
        do_reset();
        op_valid = 1; op_cmd = 4'd1;
        for (int e = 1; e <= 7; e++) tick();
        op_valid = 0;
        resp_in = 2'd1; resp_tag_in = 2'd0; resp_data_in = 32'd4;
        tick();
        resp_in = 2'd0;
        repeat (11) tick();
        resp_in = 2'd1; resp_tag_in = 2'd3; resp_data_in = 32'd33;
        tick();
        resp_in = 2'd0;
        checks++; if (res_valid !== 1'b1 || res_tag !== 2'd3 || res_timeout !== 1'b0 || res_data !== 32'd33) begin errors++; $display("[TB] FAIL collide_real: got v=%b t=%0d to=%b d=%0d expected 1/3/0/33", res_valid, res_tag, res_timeout, res_data); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_tag !== 2'd1 || res_timeout !== 1'b1 || res_resp !== 2'd0) begin errors++; $display("[TB] FAIL collide_to1: got v=%b t=%0d to=%b r=%0d expected 1/1/1/0", res_valid, res_tag, res_timeout, res_resp); end
        tick();
        checks++; if (res_valid !== 1'b1 || res_tag !== 2'd2 || res_timeout !== 1'b1) begin errors++; $display("[TB] FAIL collide_to2: got v=%b t=%0d to=%b expected 1/2/1", res_valid, res_tag, res_timeout); end
    endtask

    task automatic test_spurious_reset();
        do_reset();
        resp_in = 2'd1; resp_tag_in = 2'd2; resp_data_in = 32'd9;
        tick();
        resp_in = 2'd0;
        checks++; if (spurious_err !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL spurious_pulse: got s=%b v=%b busy=%b expected 1/0/0", spurious_err, res_valid, busy); end
        tick();
        checks++; if (spurious_err !== 1'b0) begin errors++; $display("[TB] FAIL spurious_end: got %b expected 0", spurious_err); end
        op_valid = 1; op_cmd = 4'd5; op_a = 32'h55; op_b = 32'd3;
        tick();
        op_valid = 0;
        checks++; if (req_cmd_out !== 4'd5 || busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_send1: got cmd=%0d busy=%b expected 5/1", req_cmd_out, busy); end
        reset = 1'b1;
        model_reset();
        #1;
        checks++; if (req_cmd_out !== 4'd0 || req_data_out !== 32'd0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_drop: got cmd=%0d data=%0h busy=%b expected 0/0/0", req_cmd_out, req_data_out, busy); end
        @(negedge c_clk);
        reset = 1'b0;
        checks++; if (op_ready !== 1'b1 || op_tag !== 2'd0) begin errors++; $display("[TB] FAIL midreset_ready: got ready=%b tag=%0d expected 1/0", op_ready, op_tag); end
        resp_in = 2'd1; resp_tag_in = 2'd0;
        tick();
        resp_in = 2'd0;
        checks++; if (spurious_err !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("[TB] FAIL midreset_late: got s=%b v=%b expected 1/0", spurious_err, res_valid); end
    endtask

    task automatic test_random();
        int r;
        int t;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            op_valid = ($urandom_range(0, 99) < 60);
            op_cmd = 4'($urandom); op_a = $urandom; op_b = $urandom;
            resp_data_in = $urandom; resp_tag_in = 2'($urandom);
            r = $urandom_range(0, 99);
            if (r < 25 && m_out != 0) begin
                t = $urandom_range(0, 3);
                while (!m_out[t]) t = $urandom_range(0, 3);
                resp_tag_in = 2'(t);
                resp_in = 2'($urandom_range(1, 3));
            end else if (r < 30) begin
                resp_in = 2'($urandom_range(1, 3));
            end else begin
                resp_in = 2'd0;
            end
            checks++; if (op_ready !== m_ready()) begin errors++; $display("[TB] FAIL rnd_ready c%0d: got %b expected %b", c, op_ready, m_ready()); end
            if (m_ready()) begin
                checks++; if (op_tag !== 2'(m_free_tag())) begin errors++; $display("[TB] FAIL rnd_tag c%0d: got %0d expected %0d", c, op_tag, m_free_tag()); end
            end
            tick();
            checks++; if ({req_cmd_out, req_data_out, req_tag_out} !== {e_req_cmd, e_req_data, e_req_tag}) begin errors++; $display("[TB] FAIL rnd_req c%0d: got %0h/%0h/%0h expected %0h/%0h/%0h", c, req_cmd_out, req_data_out, req_tag_out, e_req_cmd, e_req_data, e_req_tag); end
            checks++; if ({res_valid, res_resp, res_data, res_tag, res_timeout} !== {e_res_valid, e_res_resp, e_res_data, e_res_tag, e_res_to}) begin errors++; $display("[TB] FAIL rnd_res c%0d: got v=%b r=%0d d=%0h t=%0d to=%b expected v=%b r=%0d d=%0h t=%0d to=%b", c, res_valid, res_resp, res_data, res_tag, res_timeout, e_res_valid, e_res_resp, e_res_data, e_res_tag, e_res_to); end
            checks++; if (spurious_err !== e_spur) begin errors++; $display("[TB] FAIL rnd_spur c%0d: got %b expected %b", c, spurious_err, e_spur); end
            checks++; if (busy !== e_busy) begin errors++; $display("[TB] FAIL rnd_busy c%0d: got %b expected %b", c, busy, e_busy); end
        end
        op_valid = 0; resp_in = 0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_exhaust();
        test_timeout();
        test_collision();
        test_spurious_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
